gpmc_sync_burst: RTL and testbench
==================================

Name: gpmc_sync_burst

Overview:
- Parametrised GPMC synchronous slave for address/data-multiplexed mode, clocked by gpmc_clk.
- Adds multi-beat read and write bursts with per-beat address auto-increment.
- Adds a pipelined host read path with configurable latency, driving the GPMC WAIT pin until read data is ready.
- Pad tri-state is exposed as separate in/out/oe ports; the top level wraps them in SB_IO.

Parameters:
- ADDR_WIDTH, 16: host address width; must be <= DATA_WIDTH. The address is taken from gpmc_ad_in[ADDR_WIDTH-1:0].
- DATA_WIDTH, 16: AD bus and host data width.
- RD_LATENCY, 2: edges from rd_en assertion to valid data_in; range 1..4.
- MAX_BURST, 8: maximum beats accepted per address phase; range 1..256.

Ports:
- gpmc_clk, in, 1: sole clock. All state updates on the falling edge, since GPMC launches on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- gpmc_ad_in, in, DATA_WIDTH: AD pad input.
- gpmc_ad_out, out, DATA_WIDTH: AD pad output data.
- gpmc_ad_oe, out, 1: AD pad output enable.
- gpmc_adv_n, in, 1: address valid, active low.
- gpmc_cs_n, in, 1: chip select, active low.
- gpmc_we_n, in, 1: write enable, active low.
- gpmc_oe_n, in, 1: output enable, active low.
- gpmc_wait, out, 1: high = slave not ready (GPMC configured wait-active-high).
- rd_en, out, 1: host read strobe, one per beat.
- wr_en, out, 1: host write strobe, one per beat.
- address_valid, out, 1: address latched and CS active.
- address, out, ADDR_WIDTH: beat address presented with rd_en/wr_en.
- data_out, out, DATA_WIDTH: write data, valid with wr_en.
- data_in, in, DATA_WIDTH: host read data, valid RD_LATENCY edges after rd_en.
- burst_err, out, 1: sticky flag, set on a beat beyond MAX_BURST; cleared on the next address phase.

Behaviour:
- Reset values: every output and internal state is 0, state = IDLE. rst asserted mid-burst aborts immediately; gpmc_ad_oe and gpmc_wait drop asynchronously.
- States: IDLE, ADDR, WRITE, READ.
- cs_n high, sampled in any state:
  - go to IDLE next edge;
  - address <= 0, address_valid <= 0, gpmc_ad_oe <= 0, gpmc_wait <= 0;
  - in-flight read data discarded.
- Address phase (cs_n=0 and adv_n=0, in any state):
  - address <= ad_in[ADDR_WIDTH-1:0], address_valid <= 1;
  - beat count <= 0, burst_err <= 0, read pipeline flushed, go to ADDR.
  - adv_n low mid-burst therefore restarts cleanly.
- ADDR (adv_n=1):
  - we_n=0: go to WRITE and take beat 0 on this same edge.
  - else oe_n=0: go to READ and issue rd_en for beat 0 on this edge.
  - else: remain in ADDR.
- WRITE, on each edge with cs_n=0, adv_n=1, we_n=0:
  - if beat count < MAX_BURST: wr_en=1 for one cycle; data_out = ad_in; address = current beat address; address increments by 1 after the beat; beat count +1.
  - else: no wr_en, burst_err <= 1.
  - we_n high while cs_n low: no strobe; state held.
- READ:
  - gpmc_ad_oe = 1 while in READ and oe_n=0.
  - rd_en is issued each edge with oe_n=0 and beat count < MAX_BURST; address increments after each issue.
  - A shift register tags in-flight reads. data_in is sampled exactly RD_LATENCY edges after the matching rd_en and loaded into gpmc_ad_out.
  - gpmc_wait = 1 from READ entry until the edge that loads the first word, then 0. Subsequent words load one per edge.
  - Reads beyond MAX_BURST: no rd_en, burst_err <= 1, gpmc_ad_out holds the last word.
  - oe_n high: stop issuing, gpmc_ad_oe <= 0, drop in-flight tags, return to ADDR.
  - Up to RD_LATENCY words may be prefetched and discarded; host reads must be side-effect free.
- Address arithmetic wraps modulo 2^ADDR_WIDTH (0xFFFF + 1 = 0x0000 at default width).
- rd_en and wr_en are never asserted on the same edge. Each is a single-cycle pulse per beat, never held.
- Beat counter width is clog2(MAX_BURST+1) and saturates at MAX_BURST.

Test Plan:
- Single write: address phase with AD=0x0040, then we_n=0 and AD=0xBEEF for one edge -> exactly one wr_en pulse, address=0x0040, data_out=0xBEEF; burst_err=0.
- 4-beat write burst at 0x0100 with data 1,2,3,4 -> wr_en on 4 consecutive edges, addresses 0x0100..0x0103, data_out 1..4.
- Read burst at 0x0200, RD_LATENCY=2, host returns data = address -> gpmc_wait high for the first 2 edges, then gpmc_ad_out = 0x0200, 0x0201, 0x0202 on successive edges; gpmc_ad_oe high throughout; no wr_en.
- Burst overflow, MAX_BURST=8, 10 write beats -> 8 wr_en pulses only, burst_err=1; the next address phase clears burst_err to 0.
- Address wrap: burst at 0xFFFE, 3 beats -> addresses 0xFFFE, 0xFFFF, 0x0000.
- Abort: cs_n high, or rst pulsed, mid read burst -> next edge (asynchronous for rst) gpmc_ad_oe=0, gpmc_wait=0, address_valid=0, address=0; in-flight data never reaches gpmc_ad_out.

Source files
------------

// File: rtl/gpmc_sync_burst.sv
// rtl/gpmc_sync_burst.sv - GPMC synchronous AD-muxed burst slave with pipelined host read path
module gpmc_sync_burst #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 2,
    parameter int MAX_BURST  = 8
) (
    input  logic                  gpmc_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
    output logic [DATA_WIDTH-1:0] gpmc_ad_out,
    output logic                  gpmc_ad_oe,
    input  logic                  gpmc_adv_n,
    input  logic                  gpmc_cs_n,
    input  logic                  gpmc_we_n,
    input  logic                  gpmc_oe_n,
    output logic                  gpmc_wait,
    output logic                  rd_en,
    output logic                  wr_en,
    output logic                  address_valid,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  burst_err
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]         MAX_CNT = CW'(MAX_BURST);
    localparam logic [RD_LATENCY-1:0] TAG_LSB = RD_LATENCY'(1);

    typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} state_t;

    state_t                  state;
    logic [CW-1:0]           beat_cnt;
    logic [ADDR_WIDTH-1:0]   addr_ptr;
    logic [RD_LATENCY-1:0]   rd_tag;

    logic active, beat_ok, wr_req, rd_req, rd_issue, rd_load;
    logic [RD_LATENCY-1:0] rd_tag_next;

    always_comb begin
        active   = !gpmc_cs_n && gpmc_adv_n;
        beat_ok  = beat_cnt < MAX_CNT;
        wr_req   = active && !gpmc_we_n && (state == ADDR || state == WRITE);
        rd_req   = active && !gpmc_oe_n &&
                   ((state == ADDR && gpmc_we_n) || state == READ);
        rd_issue = rd_req && beat_ok;
        // A tag reaching the top bit marks the edge its data_in is valid.
        rd_load  = active && state == READ && !gpmc_oe_n && rd_tag[RD_LATENCY-1];
        rd_tag_next = (rd_tag << 1) | (rd_issue ? TAG_LSB : '0);
    end

    always_ff @(negedge gpmc_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            addr_ptr      <= '0;
            rd_tag        <= '0;
            gpmc_ad_out   <= '0;
            gpmc_ad_oe    <= 1'b0;
            gpmc_wait     <= 1'b0;
            rd_en         <= 1'b0;
            wr_en         <= 1'b0;
            address_valid <= 1'b0;
            address       <= '0;
            data_out      <= '0;
            burst_err     <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            if (gpmc_cs_n) begin
                state         <= IDLE;
                address       <= '0;
                address_valid <= 1'b0;
                gpmc_ad_oe    <= 1'b0;
                gpmc_wait     <= 1'b0;
                rd_tag        <= '0;
            end else if (!gpmc_adv_n) begin
                state         <= ADDR;
                address       <= gpmc_ad_in[ADDR_WIDTH-1:0];
                addr_ptr      <= gpmc_ad_in[ADDR_WIDTH-1:0];
                address_valid <= 1'b1;
                beat_cnt      <= '0;
                burst_err     <= 1'b0;
                rd_tag        <= '0;
                gpmc_ad_oe    <= 1'b0;
                gpmc_wait     <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (!gpmc_we_n) begin
                            state <= WRITE;
                        end else if (!gpmc_oe_n) begin
                            state      <= READ;
                            gpmc_ad_oe <= 1'b1;
                            gpmc_wait  <= 1'b1;
                        end
                    end
                    READ: begin
                        if (gpmc_oe_n) begin
                            state      <= ADDR;
                            gpmc_ad_oe <= 1'b0;
                            gpmc_wait  <= 1'b0;
                        end else begin
                            gpmc_ad_oe <= 1'b1;
                        end
                    end
                    default: ;
                endcase

                if (state == READ && gpmc_oe_n)
                    rd_tag <= '0;
                else
                    rd_tag <= rd_tag_next;

                if (rd_load) begin
                    gpmc_ad_out <= data_in;
                    gpmc_wait   <= 1'b0;
                end

                // One beat per edge; wr_req and rd_req are mutually exclusive.
                if (wr_req || rd_req) begin
                    if (beat_ok) begin
                        wr_en    <= wr_req;
                        rd_en    <= rd_req;
                        address  <= addr_ptr;
                        addr_ptr <= addr_ptr + ADDR_WIDTH'(1);
                        beat_cnt <= beat_cnt + CW'(1);
                        if (wr_req)
                            data_out <= gpmc_ad_in;
                    end else begin
                        burst_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gpmc_sync_burst.sv
// tb/tb_gpmc_sync_burst.sv - scoreboard bench for gpmc_sync_burst
module tb_gpmc_sync_burst;

    logic        gpmc_clk = 1'b0;
    logic        rst;
    logic [15:0] gpmc_ad_in;
    logic [15:0] gpmc_ad_out;
    logic        gpmc_ad_oe;
    logic        gpmc_adv_n, gpmc_cs_n, gpmc_we_n, gpmc_oe_n;
    logic        gpmc_wait;
    logic        rd_en, wr_en, address_valid, burst_err;
    logic [15:0] address, data_out, data_in;

    always #5 gpmc_clk = ~gpmc_clk;

    gpmc_sync_burst #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .RD_LATENCY(2), .MAX_BURST(8)
    ) dut (
        .gpmc_clk     (gpmc_clk),
        .rst          (rst),
        .gpmc_ad_in   (gpmc_ad_in),
        .gpmc_ad_out  (gpmc_ad_out),
        .gpmc_ad_oe   (gpmc_ad_oe),
        .gpmc_adv_n   (gpmc_adv_n),
        .gpmc_cs_n    (gpmc_cs_n),
        .gpmc_we_n    (gpmc_we_n),
        .gpmc_oe_n    (gpmc_oe_n),
        .gpmc_wait    (gpmc_wait),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .address_valid(address_valid),
        .address      (address),
        .data_out     (data_out),
        .data_in      (data_in),
        .burst_err    (burst_err)
    );

    // Host memory returns data == address, two edges after rd_en.
    logic        hs_v0 = 1'b0, hs_v1 = 1'b0;
    logic [15:0] hs_a0 = '0, hs_a1 = '0;
    always @(posedge gpmc_clk) begin
        hs_v0 <= rd_en;
        hs_a0 <= address;
        hs_v1 <= hs_v0;
        hs_a1 <= hs_a0;
    end
    assign data_in = hs_v1 ? hs_a1 : 16'hDEAD;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_out[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: outputs settle on the falling edge, sampled on the rising edge.
    always @(posedge gpmc_clk) begin
        if (!rst) begin
            if (rd_en && wr_en)
                chk("rd_en_and_wr_en", 32'd1, 32'd0);
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr_en", {address, data_out}, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_beat", {address, data_out}, {e.a, e.d});
                end
            end
            if (rd_en) begin
                if (exp_rd.size() == 0)
                    chk("unexpected_rd_en", {16'h0, address}, 32'hFFFF_FFFF);
                else
                    chk("rd_addr", {16'h0, address}, {16'h0, exp_rd.pop_front()});
            end
            if (gpmc_ad_oe && !gpmc_wait) begin
                if (exp_out.size() == 0)
                    chk("unexpected_ad_out", {16'h0, gpmc_ad_out}, 32'hFFFF_FFFF);
                else
                    chk("ad_out", {16'h0, gpmc_ad_out}, {16'h0, exp_out.pop_front()});
            end
        end
    end

    task automatic cyc(input logic cs, input logic adv, input logic we, input logic oe,
                       input logic [15:0] ad);
        @(posedge gpmc_clk);
        gpmc_cs_n  = cs;
        gpmc_adv_n = adv;
        gpmc_we_n  = we;
        gpmc_oe_n  = oe;
        gpmc_ad_in = ad;
        @(negedge gpmc_clk);
        #1;
    endtask

    logic [15:0] wrap_addr [3];

    initial begin
        rst = 1'b1;
        gpmc_cs_n = 1'b1; gpmc_adv_n = 1'b1; gpmc_we_n = 1'b1; gpmc_oe_n = 1'b1;
        gpmc_ad_in = '0;
        wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF; wrap_addr[2] = 16'h0000;

        repeat (2) @(negedge gpmc_clk);
        #1;
        chk("rst_ad_oe", gpmc_ad_oe, 0);
        chk("rst_wait", gpmc_wait, 0);
        chk("rst_addr_valid", address_valid, 0);
        chk("rst_address", address, 0);
        chk("rst_burst_err", burst_err, 0);
        chk("rst_ad_out", gpmc_ad_out, 0);
        chk("rst_strobes", {rd_en, wr_en}, 0);
        @(posedge gpmc_clk);
        rst = 1'b0;

        // Single write
        cyc(0, 0, 1, 1, 16'h0040);
        chk("sw_addr_valid", address_valid, 1);
        chk("sw_address", address, 16'h0040);
        exp_wr.push_back('{a: 16'h0040, d: 16'hBEEF});
        cyc(0, 1, 0, 1, 16'hBEEF);
        chk("sw_burst_err", burst_err, 0);
        cyc(1, 1, 1, 1, 16'h0000);

        // 4-beat write burst
        cyc(0, 0, 1, 1, 16'h0100);
        for (int i = 0; i < 4; i++) begin
            exp_wr.push_back('{a: 16'h0100 + 16'(i), d: 16'(i + 1)});
            cyc(0, 1, 0, 1, 16'(i + 1));
        end
        cyc(1, 1, 1, 1, 16'h0000);

        // Read burst, latency 2
        cyc(0, 0, 1, 1, 16'h0200);
        for (int i = 0; i < 5; i++) begin
            exp_rd.push_back(16'h0200 + 16'(i));
            if (i < 3) exp_out.push_back(16'h0200 + 16'(i));
            cyc(0, 1, 1, 0, 16'h0000);
            chk("rd_wait", gpmc_wait, (i < 2) ? 1 : 0);
            chk("rd_ad_oe", gpmc_ad_oe, 1);
        end
        cyc(0, 1, 1, 1, 16'h0000);
        chk("rd_end_ad_oe", gpmc_ad_oe, 0);
        chk("rd_end_ad_out", gpmc_ad_out, 16'h0202);
        cyc(1, 1, 1, 1, 16'h0000);

        // Overflow: 10 beats, 8 accepted
        cyc(0, 0, 1, 1, 16'h0500);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_wr.push_back('{a: 16'h0500 + 16'(i), d: 16'(i + 1)});
            cyc(0, 1, 0, 1, 16'(i + 1));
            chk("ovf_burst_err", burst_err, (i < 8) ? 0 : 1);
        end
        cyc(0, 0, 1, 1, 16'h0600);
        chk("ovf_err_cleared", burst_err, 0);
        cyc(1, 1, 1, 1, 16'h0000);

        // Address wrap
        cyc(0, 0, 1, 1, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back('{a: wrap_addr[i], d: 16'h00A0 + 16'(i)});
            cyc(0, 1, 0, 1, 16'h00A0 + 16'(i));
        end
        cyc(1, 1, 1, 1, 16'h0000);

        // cs_n abort mid read
        cyc(0, 0, 1, 1, 16'h0300);
        exp_rd.push_back(16'h0300);
        cyc(0, 1, 1, 0, 16'h0000);
        chk("cs_ab_wait_pre", gpmc_wait, 1);
        chk("cs_ab_oe_pre", gpmc_ad_oe, 1);
        cyc(1, 1, 1, 0, 16'h0000);
        chk("cs_ab_ad_oe", gpmc_ad_oe, 0);
        chk("cs_ab_wait", gpmc_wait, 0);
        chk("cs_ab_addr_valid", address_valid, 0);
        chk("cs_ab_address", address, 0);
        repeat (3) cyc(1, 1, 1, 1, 16'h0000);
        chk("cs_ab_ad_out_held", gpmc_ad_out, 16'h0202);

        // rst abort mid read
        cyc(0, 0, 1, 1, 16'h0400);
        exp_rd.push_back(16'h0400);
        cyc(0, 1, 1, 0, 16'h0000);
        chk("rst_ab_wait_pre", gpmc_wait, 1);
        @(posedge gpmc_clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_ab_ad_oe", gpmc_ad_oe, 0);
        chk("rst_ab_wait", gpmc_wait, 0);
        chk("rst_ab_addr_valid", address_valid, 0);
        chk("rst_ab_address", address, 0);
        chk("rst_ab_ad_out", gpmc_ad_out, 0);
        cyc(1, 1, 1, 1, 16'h0000);
        @(posedge gpmc_clk);
        rst = 1'b0;
        repeat (3) cyc(1, 1, 1, 1, 16'h0000);
        chk("rst_ab_ad_out_after", gpmc_ad_out, 0);
        chk("rst_ab_ad_oe_after", gpmc_ad_oe, 0);

        repeat (2) cyc(1, 1, 1, 1, 16'h0000);
        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_rd_drained", exp_rd.size(), 0);
        chk("exp_out_drained", exp_out.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
